// File: rtl/stim_frame_sequencer_if.sv
// Handshake bundle between sample source, sequencer and datapath.
// master = sequencer side, slave = source/datapath side.
interface stim_frame_sequencer_if #(
  parameter int DATA_W = 10
);
  logic              src_valid;
  logic [DATA_W-1:0] src_data;
  logic              src_eof;
  logic              src_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_sop;
  logic              out_eop;
  logic              out_ready;

  modport master (
    input  src_valid,
    input  src_data,
    input  src_eof,
    input  out_ready,
    output src_ready,
    output out_valid,
    output out_data,
    output out_sop,
    output out_eop
  );

  modport slave (
    output src_valid,
    output src_data,
    output src_eof,
    output out_ready,
    input  src_ready,
    input  out_valid,
    input  out_data,
    input  out_sop,
    input  out_eop
  );
endinterface

// File: rtl/stim_frame_sequencer.sv
// Groups source samples into sop/eop frames with gaps, eof padding, abort.
// Ports: clk, rst_n (sync, low); start/abort pulses; num_frames and
// gap_cycles latched at start; bus = source in / datapath out handshakes;
// busy, done, frames_sent, short_frame (sticky), stall_cnt (saturating).
module stim_frame_sequencer #(
  parameter int DATA_W    = 10,
  parameter int FRAME_LEN = 16,
  parameter int GAP_W     = 8,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_frames,
  input  logic [GAP_W-1:0] gap_cycles,
  stim_frame_sequencer_if.master bus,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] frames_sent,
  output logic             short_frame,
  output logic [7:0]       stall_cnt
);

  localparam int IDX_W = $clog2(FRAME_LEN + 1);
  localparam logic [IDX_W-1:0] LAST =
    IDX_W'(FRAME_LEN - 1);
  localparam logic [IDX_W-1:0] FULL =
    IDX_W'(FRAME_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_GAP,
    S_PAD,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  nfr_q, nfr_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [GAP_W-1:0]  gcnt_q, gcnt_d;
  logic [CNT_W-1:0]  fs_q, fs_d;
  logic              short_q, short_d;
  logic [7:0]        stall_q, stall_d;
  logic              ov_q, ov_d;
  logic [DATA_W-1:0] od_q, od_d;
  logic              sop_q, sop_d;
  logic              eop_q, eop_d;

  logic take;
  logic room;
  logic src_rdy;
  logic src_xfer;
  logic eop_xfer;
  logic last_frame;

  assign busy = (state_q == S_RUN) |
                (state_q == S_GAP) |
                (state_q == S_PAD);
  assign done = (state_q == S_DONE);

  assign frames_sent = fs_q;
  assign short_frame = short_q;
  assign stall_cnt   = stall_q;

  assign take     = ov_q & bus.out_ready;
  assign room     = ~ov_q | bus.out_ready;
  assign src_rdy  = (state_q == S_RUN) &
                    ~bus.src_eof &
                    room &
                    (idx_q < FULL);
  assign src_xfer = src_rdy & bus.src_valid;
  assign eop_xfer = take & eop_q;

  // Frame just handed off is the last programmed one.
  assign last_frame = (nfr_q != '0) &&
                      (fs_q + CNT_W'(1) == nfr_q);

  assign bus.src_ready = src_rdy;
  assign bus.out_valid = ov_q;
  assign bus.out_data  = od_q;
  assign bus.out_sop   = sop_q;
  assign bus.out_eop   = eop_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      nfr_q   <= '0;
      gap_q   <= '0;
      gcnt_q  <= '0;
      fs_q    <= '0;
      short_q <= 1'b0;
      stall_q <= '0;
      ov_q    <= 1'b0;
      od_q    <= '0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      nfr_q   <= nfr_d;
      gap_q   <= gap_d;
      gcnt_q  <= gcnt_d;
      fs_q    <= fs_d;
      short_q <= short_d;
      stall_q <= stall_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    nfr_d   = nfr_q;
    gap_d   = gap_q;
    gcnt_d  = gcnt_q;
    fs_d    = fs_q;
    short_d = short_q;
    stall_d = stall_q;
    ov_d    = ov_q;
    od_d    = od_q;
    sop_d   = sop_q;
    eop_d   = eop_q;

    // Holding register empties on handoff;
    // a same-cycle load below refills it.
    if (take) begin
      ov_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start && !abort) begin
          nfr_d   = num_frames;
          gap_d   = gap_cycles;
          fs_d    = '0;
          short_d = 1'b0;
          stall_d = '0;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        if (src_xfer) begin
          ov_d  = 1'b1;
          od_d  = bus.src_data;
          sop_d = (idx_q == '0);
          eop_d = (idx_q == LAST);
          idx_d = idx_q + IDX_W'(1);
        end
        // Only gaps inside a frame count;
        // waiting for a frame's first sample is not a stall.
        if (idx_q != '0 && idx_q < FULL &&
            !bus.src_eof && !bus.src_valid &&
            room && stall_q != 8'hFF) begin
          stall_d = stall_q + 8'd1;
        end
        if (eop_xfer) begin
          fs_d  = fs_q + CNT_W'(1);
          idx_d = '0;
          if (last_frame) begin
            state_d = S_DONE;
          end else if (gap_q != '0) begin
            gcnt_d  = gap_q;
            state_d = S_GAP;
          end
        end else if (bus.src_eof) begin
          if (idx_q == '0 && !ov_q) begin
            state_d = S_DONE;
          end else if (idx_q != '0 &&
                       idx_q < FULL) begin
            short_d = 1'b1;
            state_d = S_PAD;
          end
        end
      end

      S_GAP: begin
        gcnt_d = gcnt_q - GAP_W'(1);
        if (gcnt_q <= GAP_W'(1)) begin
          state_d = S_RUN;
        end
      end

      S_PAD: begin
        // Any real sample still held drains
        // first, then zeros fill the frame.
        if (room && idx_q < FULL) begin
          ov_d  = 1'b1;
          od_d  = '0;
          sop_d = 1'b0;
          eop_d = (idx_q == LAST);
          idx_d = idx_q + IDX_W'(1);
        end
        if (eop_xfer) begin
          fs_d    = fs_q + CNT_W'(1);
          idx_d   = '0;
          state_d = S_DONE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort drops any unsent sample;
    // a frame whose eop went out this
    // cycle still counts.
    if (abort && busy) begin
      state_d = S_DONE;
      ov_d    = 1'b0;
      od_d    = '0;
      sop_d   = 1'b0;
      eop_d   = 1'b0;
      idx_d   = '0;
    end
  end

endmodule

// File: tb/tb_stim_frame_sequencer.sv
// Self-checking bench for stim_frame_sequencer.
// Table of runs checked against a frame-building model.
module tb_stim_frame_sequencer;

  localparam int DW = 10;
  localparam int FL = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] num_frames;
  logic [7:0]  gap_cycles;
  logic        busy;
  logic        done;
  logic [15:0] frames_sent;
  logic        short_frame;
  logic [7:0]  stall_cnt;

  stim_frame_sequencer_if #(.DATA_W(DW)) bus();

  stim_frame_sequencer #(
    .DATA_W(DW),
    .FRAME_LEN(FL),
    .GAP_W(8),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .abort(abort),
    .num_frames(num_frames),
    .gap_cycles(gap_cycles),
    .bus(bus.master),
    .busy(busy),
    .done(done),
    .frames_sent(frames_sent),
    .short_frame(short_frame),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int nfr;
    int gap;
    int nsamp;
    bit eof;
    bit seqdata;
    int vpct;
    int rpct;
    int script;
    bit tchk;
    int exp_frames;
    bit exp_short;
    int exp_stall;
  } row_t;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          sop;
    logic          eop;
  } beat_t;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] samp[$];
  beat_t         exp_q[$];
  beat_t         got_q[$];
  row_t          rows[10];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // Expected stream: consecutive FL-sample
  // chunks of the source, the last one
  // zero-filled if the source ran dry.
  task automatic build_model(input row_t r);
    beat_t b;
    int    s;
    exp_q.delete();
    for (int f = 0; f < 64; f++) begin
      if (r.nfr != 0 && f >= r.nfr) break;
      if (r.eof && f * FL >= r.nsamp) break;
      for (int k = 0; k < FL; k++) begin
        s = f * FL + k;
        b.d   = (s < r.nsamp) ? samp[s] : '0;
        b.sop = (k == 0);
        b.eop = (k == FL - 1);
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic run_row(input int id,
                         input row_t r);
    int sq = 0;
    int hold = 0;
    int stl = 0;
    int cyc = 0;
    bit held = 0;
    bit sa = 0;
    bit sb = 0;
    bit prev_hs = 0;
    logic [12:0] prev_w = '0;
    int tq[$];
    samp.delete();
    got_q.delete();
    for (int i = 0; i < r.nsamp; i++)
      samp.push_back(r.seqdata ? DW'(i)
                               : DW'($urandom));
    build_model(r);
    @(negedge clk);
    num_frames = 16'(r.nfr);
    gap_cycles = 8'(r.gap);
    bus.src_valid = 0;
    bus.src_eof = 0;
    bus.out_ready = 0;
    start = 1;
    @(negedge clk);
    start = 0;
    num_frames = 16'($urandom);
    gap_cycles = 8'($urandom);
    while (1) begin
      if (prev_hs)
        chk("hold_stable",
            {bus.out_valid, bus.out_sop,
             bus.out_eop, bus.out_data},
            prev_w);
      if (done) break;
      if (cyc >= 3000) begin
        checks++;
        errors++;
        $display("FAIL row%0d timeout: done=0 after %0d cycles, required done=1",
                 id, cyc);
        break;
      end
      if (r.script == 2) begin
        if (sq == 7 && !sa) begin
          stl = 2;
          sa = 1;
        end
        if (sq == 16 && !sb) begin
          stl = 1;
          sb = 1;
        end
      end
      bus.src_eof = r.eof && sq >= r.nsamp;
      bus.src_data = (sq < r.nsamp) ? samp[sq]
                                    : '0;
      bus.src_valid = (sq < r.nsamp) &&
                      (stl == 0) &&
                      ($urandom_range(99) < r.vpct);
      if (stl > 0) stl--;
      bus.out_ready = $urandom_range(99) < r.rpct;
      if (r.script == 1 && !held &&
          bus.out_valid && got_q.size() == 5) begin
        hold = 4;
        held = 1;
      end
      if (hold > 0) bus.out_ready = 0;
      #1;
      if (hold > 0) begin
        chk("hold_out",
            {bus.out_valid, bus.src_ready,
             bus.out_data},
            {1'b1, 1'b0, exp_q[5].d});
        hold--;
      end
      if (bus.src_eof)
        chk("ready_in_eof", bus.src_ready, 0);
      if (bus.src_valid && bus.src_ready)
        sq++;
      if (bus.out_valid && bus.out_ready) begin
        got_q.push_back({bus.out_data,
                         bus.out_sop,
                         bus.out_eop});
        tq.push_back(cyc);
      end
      prev_hs = bus.out_valid && !bus.out_ready;
      prev_w = {bus.out_valid, bus.out_sop,
                bus.out_eop, bus.out_data};
      cyc++;
      @(negedge clk);
    end
    bus.src_valid = 0;
    bus.src_eof = 0;
    bus.out_ready = 0;
    chk($sformatf("row%0d_beats", id),
        got_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() &&
                    k < got_q.size(); k++)
      chk($sformatf("row%0d_beat%0d", id, k),
          got_q[k], exp_q[k]);
    // Full-rate spacing: back-to-back inside
    // a frame; after eop the gap plus the
    // one-cycle fetch latency.
    if (r.tchk)
      for (int k = 1; k < tq.size() &&
                      k < exp_q.size(); k++)
        chk($sformatf("row%0d_space%0d", id, k),
            tq[k] - tq[k-1],
            exp_q[k-1].eop ? r.gap + 2 : 1);
    chk($sformatf("row%0d_frames", id),
        frames_sent, r.exp_frames);
    chk($sformatf("row%0d_short", id),
        short_frame, r.exp_short);
    if (r.exp_stall >= 0)
      chk($sformatf("row%0d_stall", id),
          stall_cnt, r.exp_stall);
    chk($sformatf("row%0d_idle", id),
        {busy, bus.out_valid, bus.src_ready},
        0);
  endtask

  task automatic abort_mid_frame();
    int sq = 0;
    bit hit = 0;
    @(negedge clk);
    num_frames = 1;
    gap_cycles = 0;
    start = 1;
    @(negedge clk);
    start = 0;
    for (int c = 0; c < 100; c++) begin
      if (bus.out_valid &&
          bus.out_data == DW'(9)) begin
        hit = 1;
        break;
      end
      bus.src_valid = 1;
      bus.src_data = DW'(sq);
      bus.out_ready = 1;
      #1;
      if (bus.src_ready) sq++;
      @(negedge clk);
    end
    chk("abort_reach_idx9", hit, 1);
    bus.out_ready = 0;
    @(negedge clk);
    chk("abort_stalled_idx9",
        {bus.out_valid, bus.out_data},
        {1'b1, 10'd9});
    abort = 1;
    @(negedge clk);
    abort = 0;
    chk("abort_drop",
        {bus.out_valid, bus.out_eop, done, busy},
        4'b0010);
    chk("abort_frames", frames_sent, 0);
    start = 1;
    abort = 1;
    @(negedge clk);
    start = 0;
    abort = 0;
    chk("abort_beats_start", {done, busy}, 2'b10);
    bus.src_valid = 0;
  endtask

  task automatic reset_in_gap();
    int sq = 0;
    bit seen = 0;
    @(negedge clk);
    num_frames = 2;
    gap_cycles = 10;
    start = 1;
    @(negedge clk);
    start = 0;
    for (int c = 0; c < 200 && !seen; c++) begin
      bus.src_valid = 1;
      bus.src_data = DW'(sq);
      bus.src_eof = 0;
      bus.out_ready = 1;
      #1;
      if (bus.src_ready) sq++;
      if (bus.out_valid && bus.out_eop) seen = 1;
      @(negedge clk);
    end
    chk("gap_eop_seen", seen, 1);
    repeat (2) @(negedge clk);
    chk("in_gap",
        {busy, bus.out_valid, bus.src_ready,
         frames_sent[3:0]},
        {1'b1, 1'b0, 1'b0, 4'd1});
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    chk("rst_gap_ctl",
        {busy, done, bus.out_valid, bus.out_sop,
         bus.out_eop, bus.src_ready, short_frame},
        0);
    chk("rst_gap_cnt",
        {bus.out_data, stall_cnt, frames_sent[13:0]},
        0);
    bus.src_valid = 0;
    bus.out_ready = 0;
  endtask

  initial begin
    rows[0] = '{2, 3, 40, 0, 1, 100, 100, 0, 1, 2, 0, 0};
    rows[1] = '{1, 0, 20, 0, 1, 100, 100, 1, 0, 1, 0, 0};
    rows[2] = '{2, 0, 40, 0, 1, 100, 100, 2, 0, 2, 0, 2};
    rows[3] = '{0, 2, 20, 1, 1, 100, 100, 0, 0, 2, 1, 0};
    rows[4] = '{0, 0, 32, 1, 0, 100, 100, 0, 1, 2, 0, 0};
    rows[5] = '{3, 1, 60, 0, 0, 70, 60, 0, 0, 3, 0, -1};
    rows[6] = '{0, 5, 37, 1, 0, 70, 60, 0, 0, 3, 1, -1};
    rows[7] = '{2, 1, 20, 1, 0, 50, 50, 0, 0, 2, 1, -1};
    rows[8] = '{5, 0, 16, 1, 0, 80, 40, 0, 0, 1, 0, -1};
    rows[9] = '{0, 1, 45, 1, 0, 60, 90, 0, 0, 3, 1, -1};

    rst_n = 0;
    start = 0;
    abort = 0;
    num_frames = 0;
    gap_cycles = 0;
    bus.src_valid = 0;
    bus.src_data = '0;
    bus.src_eof = 0;
    bus.out_ready = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    chk("reset_state",
        {busy, done, bus.out_valid, bus.src_ready,
         short_frame, stall_cnt, frames_sent},
        0);

    for (int i = 0; i < 3; i++) run_row(i, rows[i]);
    abort_mid_frame();
    for (int i = 3; i < 6; i++) run_row(i, rows[i]);
    reset_in_gap();
    for (int i = 6; i < 10; i++) run_row(i, rows[i]);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
